// File: rtl/wb_master_seq_pkg.sv
// Shared types and command-entry layout helpers for the Wishbone master sequencer.
// An entry is packed as {we, addr, data}, with data in the low bits.
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return aw + dw + 32'd1;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned we_bit(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/wb_master_seq_if.sv
// Host command/response handshake plus Wishbone classic bus signals of the sequencer.
interface wb_master_seq_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, wb_dat_i, wb_ack_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, wb_dat_i, wb_ack_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/wb_master_seq_cmd_fifo.sv
// Command FIFO: synchronous push/pop, full/empty from extra-MSB pointers.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module wb_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_INC = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_s, pop_s;

    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer advance; wrap is plain modulo arithmetic on PW+1 bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                mem_q[wr_ptr_q[PW-1:0]] <= data_i;
            end
        end
    end
endmodule

// File: rtl/wb_master_seq.sv
// Wishbone classic master sequencer: queues host commands and runs them one per bus cycle.
// Optional ack timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_seq
    import wb_master_pkg::*;
#(
    parameter int AW          = 3,
    parameter int DW          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input logic            clk,
    input logic            reset_n,
    wb_master_seq_if.master bus
);
    localparam int EW = entry_width(AW, DW);
    localparam int AL = addr_lsb(DW);
    localparam int WB = we_bit(AW, DW);

    state_e        state_q, state_d;
    logic [EW-1:0] entry_s, head_s;
    logic          fifo_full_s, fifo_empty_s, pop_s;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
`endif

    assign entry_s = {bus.cmd_we, bus.cmd_addr, bus.cmd_data};

    wb_cmd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (bus.cmd_valid),
        .data_i  (entry_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Sequencer next state: IDLE pops and launches, BUS waits for ack, RSP pulses the response.
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        stb_d       = stb_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    adr_d   = head_s[AL +: AW];
                    dat_d   = head_s[DW-1:0];
                    we_d    = head_s[WB];
                    stb_d   = 1'b1;
                    state_d = ST_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = {CW{1'b0}};
`endif
                end else begin
                    stb_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (bus.wb_ack_i) begin
                    rsp_data_d  = we_q ? {DW{1'b0}} : bus.wb_dat_i;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                    // Ack is tested first, so an ack on the expiry cycle completes normally.
                    if (cnt_q == CNT_LAST) begin
                        rsp_data_d  = {DW{1'b0}};
                        rsp_err_d   = 1'b1;
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RSP;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`else
                    stb_d = 1'b1;
`endif
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered bus/response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            adr_q       <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DW{1'b0}};
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= {CW{1'b0}};
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_cyc_o  = stb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.cmd_ready = !fifo_full_s;
    assign bus.busy      = !fifo_empty_s || (state_q != ST_IDLE);
`ifdef WB_MASTER_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_master_seq.sv
// Directed testbench for wb_master_seq: write, read, fill, timeout, reset, pointer wrap.
module tb_wb_master_seq;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int LIMIT = 200;

    typedef struct {
        logic          ok;
        int            t_stb;
        int            hold;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          we;
        logic          stb_after;
        logic          rv1;
        logic [DW-1:0] rd;
        logic          err;
        logic          rv2;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset_n;
    int            checks = 0;
    int            failures = 0;
    int            cyc_cnt = 0;
    int            t_acc;
    logic          acc_ok;
    logic [DW-1:0] slave_mem [8];

    wb_master_seq_if #(.AW(AW), .DW(DW)) bus ();

    wb_master_seq #(.AW(AW), .DW(DW), .FIFO_DEPTH(4), .TIMEOUT_CYC(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Offer a command from a negedge until it is accepted; returns the decision cycle.
    task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output logic ok, output int t);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready;
        t  = cyc_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Slave model: wait for stb, stall wait_cyc cycles, ack, then observe the response.
    task automatic serve(input int wait_cyc, input logic [DW-1:0] rdata, input logic use_mem,
                         output obs_t o);
        int n = 0;
        o = '{default: 0};
        while (!bus.wb_stb_o && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        o.ok    = bus.wb_stb_o;
        o.t_stb = cyc_cnt;
        o.adr   = bus.wb_adr_o;
        o.dat   = bus.wb_dat_o;
        o.we    = bus.wb_we_o;
        o.hold  = 1;
        for (int k = 0; k < wait_cyc; k++) begin
            @(negedge clk);
            if (bus.wb_stb_o && bus.wb_cyc_o && bus.wb_adr_o == o.adr &&
                bus.wb_dat_o == o.dat && bus.wb_we_o == o.we) o.hold++;
        end
        if (o.we) slave_mem[o.adr] = o.dat;
        bus.wb_ack_i = o.ok;
        bus.wb_dat_i = use_mem ? slave_mem[o.adr] : rdata;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'h00;
        o.stb_after  = bus.wb_stb_o | bus.wb_cyc_o;
        o.rv1        = bus.rsp_valid;
        o.rd         = bus.rsp_data;
        o.err        = bus.rsp_err;
        @(negedge clk);
        o.rv2 = bus.rsp_valid;
    endtask

    task automatic test_reset;
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 3'd0;
        bus.cmd_data  = 8'h00;
        bus.wb_ack_i  = 1'b0;
        bus.wb_dat_i  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if ({bus.wb_stb_o, bus.wb_cyc_o, bus.wb_we_o} !== 3'b000) begin
            failures++; $display("FAIL reset_stb_cyc_we got=%b exp=000", {bus.wb_stb_o, bus.wb_cyc_o, bus.wb_we_o}); end
        checks++; if ({bus.wb_adr_o, bus.wb_dat_o} !== 11'h000) begin
            failures++; $display("FAIL reset_adr_dat got=%h exp=000", {bus.wb_adr_o, bus.wb_dat_o}); end
        checks++; if (bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if ({bus.busy, bus.rsp_valid, bus.rsp_err} !== 3'b000) begin
            failures++; $display("FAIL reset_busy_rv_err got=%b exp=000", {bus.busy, bus.rsp_valid, bus.rsp_err}); end
        checks++; if (bus.rsp_data !== 8'h00) begin
            failures++; $display("FAIL reset_rsp_data got=%h exp=00", bus.rsp_data); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        obs_t o;
        push(1'b1, 3'd3, 8'hA5, acc_ok, t_acc);
        checks++; if (bus.wb_stb_o !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL wr_queued stb/busy got=%b%b exp=01", bus.wb_stb_o, bus.busy); end
        serve(0, 8'hEE, 1'b0, o);
        checks++; if (o.t_stb !== t_acc + 2) begin
            failures++; $display("FAIL wr_latency got=%0d exp=%0d", o.t_stb, t_acc + 2); end
        checks++; if ({o.adr, o.dat, o.we} !== {3'd3, 8'hA5, 1'b1}) begin
            failures++; $display("FAIL wr_bus adr/dat/we got=%h/%h/%b exp=3/a5/1", o.adr, o.dat, o.we); end
        checks++; if ({o.stb_after, o.rv1, o.err, o.rv2} !== 4'b0100) begin
            failures++; $display("FAIL wr_rsp stb_after/rv1/err/rv2 got=%b exp=0100", {o.stb_after, o.rv1, o.err, o.rv2}); end
        checks++; if (o.rd !== 8'h00) begin
            failures++; $display("FAIL wr_rsp_data got=%h exp=00", o.rd); end
    endtask

    task automatic test_read;
        obs_t o;
        push(1'b0, 3'd4, 8'h00, acc_ok, t_acc);
        serve(5, 8'h3C, 1'b0, o);
        checks++; if (o.t_stb !== t_acc + 2) begin
            failures++; $display("FAIL rd_latency got=%0d exp=%0d", o.t_stb, t_acc + 2); end
        checks++; if ({o.adr, o.we} !== {3'd4, 1'b0}) begin
            failures++; $display("FAIL rd_bus adr/we got=%h/%b exp=4/0", o.adr, o.we); end
        checks++; if (o.hold !== 6) begin
            failures++; $display("FAIL rd_stb_hold got=%0d exp=6", o.hold); end
        checks++; if ({o.rv1, o.err, o.rd, o.rv2} !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin
            failures++; $display("FAIL rd_rsp rv1/err/data/rv2 got=%b/%b/%h/%b exp=1/0/3c/0", o.rv1, o.err, o.rd, o.rv2); end
        checks++; if (bus.rsp_data !== 8'h3C) begin
            failures++; $display("FAIL rd_data_hold got=%h exp=3c", bus.rsp_data); end
    endtask

    task automatic test_fill;
        obs_t o [6];
        logic ok6;
        int   t6;
        int   n_ok = 0;
        // First command goes straight onto the stalled bus; the next four fill the FIFO.
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 3'(i), 8'h50 + 8'(i), ok6, t6);
            if (ok6) n_ok++;
        end
        checks++; if (n_ok !== 5) begin
            failures++; $display("FAIL fill_accepted got=%0d exp=5", n_ok); end
        checks++; if (bus.cmd_ready !== 1'b0) begin
            failures++; $display("FAIL fill_full_ready got=%b exp=0", bus.cmd_ready); end
        checks++; if (bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== 3'd0) begin
            failures++; $display("FAIL fill_stalled stb/adr got=%b/%h exp=1/0", bus.wb_stb_o, bus.wb_adr_o); end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_addr  = 3'd5;
        bus.cmd_data  = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.cmd_ready !== 1'b0) begin
                failures++; $display("FAIL fill_holdoff_%0d got=%b exp=0", k, bus.cmd_ready); end
        end
        fork
            push(1'b1, 3'd5, 8'h55, ok6, t6);
            begin
                for (int i = 0; i < 6; i++) serve(0, 8'h00, 1'b0, o[i]);
            end
        join
        for (int i = 0; i < 6; i++) begin
            checks++; if ({o[i].ok, o[i].adr, o[i].dat, o[i].we, o[i].rv1} !== {1'b1, 3'(i), 8'h50 + 8'(i), 1'b1, 1'b1}) begin
                failures++; $display("FAIL fill_order_%0d ok/adr/dat/we/rv got=%b/%h/%h/%b/%b exp=1/%h/%h/1/1",
                                     i, o[i].ok, o[i].adr, o[i].dat, o[i].we, o[i].rv1, 3'(i), 8'h50 + 8'(i)); end
        end
        checks++; if (ok6 !== 1'b1 || t6 !== o[1].t_stb) begin
            failures++; $display("FAIL fill_slot_free ok/cycle got=%b/%0d exp=1/%0d", ok6, t6, o[1].t_stb); end
        checks++; if (o[2].t_stb - o[1].t_stb !== 3) begin
            failures++; $display("FAIL fill_throughput got=%0d exp=3", o[2].t_stb - o[1].t_stb); end
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL fill_drained busy/ready got=%b/%b exp=0/1", bus.busy, bus.cmd_ready); end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        obs_t o;
        int   n  = 0;
        int   hi = 0;
        push(1'b0, 3'd6, 8'h00, acc_ok, t_acc);
        serve(0, 8'h77, 1'b0, o);
        checks++; if (o.rd !== 8'h77) begin
            failures++; $display("FAIL to_pre_read got=%h exp=77", o.rd); end
        push(1'b0, 3'd5, 8'h00, acc_ok, t_acc);
        while (!bus.wb_stb_o && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        while (bus.wb_stb_o && hi < LIMIT) begin
            hi++;
            @(negedge clk);
        end
        checks++; if (hi !== 10) begin
            failures++; $display("FAIL to_stb_cycles got=%0d exp=10", hi); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
            failures++; $display("FAIL to_rsp rv/err/data got=%b/%b/%h exp=1/1/00", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL to_rsp_pulse got=%b exp=0", bus.rsp_valid); end
        push(1'b0, 3'd2, 8'h00, acc_ok, t_acc);
        serve(9, 8'h9B, 1'b0, o);
        checks++; if ({o.hold, o.rv1, o.err, o.rd} !== {32'd10, 1'b1, 1'b0, 8'h9B}) begin
            failures++; $display("FAIL to_ack_at_expiry hold/rv/err/data got=%0d/%b/%b/%h exp=10/1/0/9b", o.hold, o.rv1, o.err, o.rd); end
        push(1'b1, 3'd1, 8'h42, acc_ok, t_acc);
        serve(0, 8'h00, 1'b0, o);
        checks++; if ({o.adr, o.dat, o.rv1, o.err, o.rd} !== {3'd1, 8'h42, 1'b1, 1'b0, 8'h00}) begin
            failures++; $display("FAIL to_next_cmd adr/dat/rv/err/data got=%h/%h/%b/%b/%h exp=1/42/1/0/00", o.adr, o.dat, o.rv1, o.err, o.rd); end
    endtask
`else
    task automatic test_timeout;
        obs_t o;
        push(1'b0, 3'd6, 8'h00, acc_ok, t_acc);
        serve(30, 8'hC3, 1'b0, o);
        checks++; if ({o.hold, o.rv1, o.err, o.rd} !== {32'd31, 1'b1, 1'b0, 8'hC3}) begin
            failures++; $display("FAIL long_wait hold/rv/err/data got=%0d/%b/%b/%h exp=31/1/0/c3", o.hold, o.rv1, o.err, o.rd); end
    endtask
`endif

    task automatic test_reset_mid;
        int rv_seen  = 0;
        int stb_seen = 0;
        push(1'b1, 3'd1, 8'h11, acc_ok, t_acc);
        push(1'b1, 3'd2, 8'h22, acc_ok, t_acc);
        push(1'b1, 3'd3, 8'h33, acc_ok, t_acc);
        checks++; if (bus.wb_stb_o !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL rst_pre stb/busy got=%b/%b exp=1/1", bus.wb_stb_o, bus.busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.wb_stb_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
            failures++; $display("FAIL rst_async stb/cyc got=%b/%b exp=0/0", bus.wb_stb_o, bus.wb_cyc_o); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) rv_seen++;
            if (bus.wb_stb_o) stb_seen++;
        end
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL rst_after busy/ready got=%b/%b exp=0/1", bus.busy, bus.cmd_ready); end
        checks++; if (rv_seen !== 0 || stb_seen !== 0) begin
            failures++; $display("FAIL rst_no_activity rsp/stb got=%0d/%0d exp=0/0", rv_seen, stb_seen); end
    endtask

    task automatic test_wrap;
        obs_t          ow, orr;
        logic          ok_w, ok_r;
        logic [AW-1:0] a;
        logic [DW-1:0] wdat;
        for (int i = 0; i < 8; i++) slave_mem[i] = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            a    = 3'(i % 8);
            wdat = 8'(i * 29 + 17);
            push(1'b1, a, wdat, ok_w, t_acc);
            push(1'b0, a, 8'h00, ok_r, t_acc);
            serve(0, 8'h00, 1'b1, ow);
            serve(i % 3, 8'h00, 1'b1, orr);
            checks++; if ({ok_w, ok_r, ow.adr, ow.dat, ow.we, ow.rd, ow.err} !== {1'b1, 1'b1, a, wdat, 1'b1, 8'h00, 1'b0}) begin
                failures++; $display("FAIL wrap_wr_%0d ok/adr/dat/we/rd/err got=%b%b/%h/%h/%b/%h/%b exp=11/%h/%h/1/00/0",
                                     i, ok_w, ok_r, ow.adr, ow.dat, ow.we, ow.rd, ow.err, a, wdat); end
            checks++; if ({orr.adr, orr.we, orr.rv1, orr.rd} !== {a, 1'b0, 1'b1, wdat}) begin
                failures++; $display("FAIL wrap_rd_%0d adr/we/rv/rd got=%h/%b/%b/%h exp=%h/0/1/%h",
                                     i, orr.adr, orr.we, orr.rv1, orr.rd, a, wdat); end
        end
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL wrap_end busy/ready got=%b/%b exp=0/1", bus.busy, bus.cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fill();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
